// File: rtl/bridge_rx.sv
`default_nettype none
// ============================================================================
//  Module   : bridge_rx
//  Brief    : Host-to-FPGA half of the UART bridge. Parses ASCII request
//             frames ('R'+4 hex addr, 'W'+4 hex addr+4 hex data, each ended
//             by CR or LF) and issues one bus transaction per valid frame.
//  Revision : 1.0 - initial release
// ============================================================================
module bridge_rx #(
   parameter int IDLE_TIMEOUT = 0   // max idle cycles inside a frame; 0 = never abort
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [7:0]  data_i,
   input  logic        valid_i,
   output logic [15:0] addr_o,
   output logic [15:0] data_o,
   output logic        rw_o,
   output logic        valid_o
);

   // Counter only has to hold values up to IDLE_TIMEOUT-1.
   localparam int             CW          = (IDLE_TIMEOUT < 2) ? 1 : $clog2(IDLE_TIMEOUT);
   localparam logic [CW-1:0]  c_tmo_last  = CW'(IDLE_TIMEOUT - 1);
   localparam logic [7:0]     c_chr_r     = 8'h52;
   localparam logic [7:0]     c_chr_w     = 8'h57;
   localparam logic [7:0]     c_chr_cr    = 8'h0D;
   localparam logic [7:0]     c_chr_lf    = 8'h0A;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ADDR = 2'd1,
      S_DATA = 2'd2
   } state_t;

   state_t          r_state;
   logic            r_rw_pend;     // frame type of the frame being parsed
   logic [2:0]      r_digits;      // hex digits received in the current field
   logic [15:0]     r_addr_sr;     // address shift register (never visible until emit)
   logic [15:0]     r_data_sr;     // data shift register (never visible until emit)
   logic [CW-1:0]   r_tmo;
   logic [15:0]     r_addr;
   logic [15:0]     r_data;
   logic            r_rw;
   logic            r_valid;

   logic            w_is_hex;
   logic [3:0]      w_nib;
   logic            w_is_term;
   logic            w_is_start;
   logic            w_tmo_en;

   assign w_is_term  = (data_i == c_chr_cr) || (data_i == c_chr_lf);
   assign w_is_start = (data_i == c_chr_r)  || (data_i == c_chr_w);
   assign w_tmo_en   = (IDLE_TIMEOUT != 0);

   // Decode an ASCII hex digit (either case) into a nibble.
   always_comb begin
      w_is_hex = 1'b0;
      w_nib    = 4'd0;
      if (data_i >= 8'h30 && data_i <= 8'h39) begin
         w_is_hex = 1'b1;
         w_nib    = data_i[3:0];
      end else if ((data_i >= 8'h41 && data_i <= 8'h46) ||
                   (data_i >= 8'h61 && data_i <= 8'h66)) begin
         w_is_hex = 1'b1;
         w_nib    = data_i[3:0] + 4'd9;
      end
   end

   // Frame parser, idle timeout and registered bus outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_rw_pend <= 1'b0;
         r_digits  <= 3'd0;
         r_addr_sr <= 16'd0;
         r_data_sr <= 16'd0;
         r_tmo     <= '0;
         r_addr    <= 16'd0;
         r_data    <= 16'd0;
         r_rw      <= 1'b0;
         r_valid   <= 1'b0;
      end else begin
         r_valid <= 1'b0;
         if (valid_i) begin
            r_tmo <= '0;
            if (w_is_start) begin
               // A start byte always (re)starts a frame, discarding any partial one.
               r_state   <= S_ADDR;
               r_rw_pend <= (data_i == c_chr_w);
               r_digits  <= 3'd0;
               r_addr_sr <= 16'd0;
               r_data_sr <= 16'd0;
            end else begin
               case (r_state)
                  S_IDLE: begin
                     // Stray bytes, including the LF of a CR-LF pair, are ignored.
                  end
                  S_ADDR: begin
                     if (w_is_hex) begin
                        if (r_digits == 3'd4) begin
                           r_state <= S_IDLE;
                        end else begin
                           r_addr_sr <= {r_addr_sr[11:0], w_nib};
                           if (r_digits == 3'd3 && r_rw_pend) begin
                              r_state  <= S_DATA;
                              r_digits <= 3'd0;
                           end else begin
                              r_digits <= r_digits + 3'd1;
                           end
                        end
                     end else if (w_is_term && r_digits == 3'd4) begin
                        // Only a read can sit here with four digits; writes moved on to DATA.
                        r_addr  <= r_addr_sr;
                        r_data  <= 16'd0;
                        r_rw    <= 1'b0;
                        r_valid <= 1'b1;
                        r_state <= S_IDLE;
                     end else begin
                        r_state <= S_IDLE;
                     end
                  end
                  S_DATA: begin
                     if (w_is_hex) begin
                        if (r_digits == 3'd4) begin
                           r_state <= S_IDLE;
                        end else begin
                           r_data_sr <= {r_data_sr[11:0], w_nib};
                           r_digits  <= r_digits + 3'd1;
                        end
                     end else if (w_is_term && r_digits == 3'd4) begin
                        r_addr  <= r_addr_sr;
                        r_data  <= r_data_sr;
                        r_rw    <= 1'b1;
                        r_valid <= 1'b1;
                        r_state <= S_IDLE;
                     end else begin
                        r_state <= S_IDLE;
                     end
                  end
                  default: r_state <= S_IDLE;
               endcase
            end
         end else if (w_tmo_en && r_state != S_IDLE) begin
            // Abort when this idle cycle would bring the count to IDLE_TIMEOUT;
            // a byte arriving in this same cycle takes the branch above instead.
            if (r_tmo == c_tmo_last) begin
               r_state <= S_IDLE;
               r_tmo   <= '0;
            end else begin
               r_tmo <= r_tmo + 1'b1;
            end
         end
      end
   end

   assign addr_o  = r_addr;
   assign data_o  = r_data;
   assign rw_o    = r_rw;
   assign valid_o = r_valid;

endmodule
`default_nettype wire
